// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: immediate format select codes and the
// default datapath width used by the decode/execute stages.
package riscv_pkg;

  // Default datapath width (32 or 64).
  localparam int XLEN_DEFAULT = 32;

  // Immediate format select codes carried on immsrc.
  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_SH  = 3'b110;
  localparam logic [2:0] IMM_RSV = 3'b111;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: extracts and extends the immediate for
// every RV32I/RV64I format at XLEN width. Reusable by any stage.
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instruction,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Shift amount field is one bit wider on RV64.
  logic [5:0] shamt;

  generate
    if (XLEN == 64) begin : g_shamt64
      assign shamt = instruction[25:20];
    end else begin : g_shamt32
      assign shamt = {1'b0, instruction[24:20]};
    end
  endgenerate

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instruction[6:0];

  // Format select; signed casts widen with copies of inst[31].
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (immsrc)
      IMM_I:   imm = XLEN'($signed(instruction[31:20]));
      IMM_S:   imm = XLEN'($signed({instruction[31:25], instruction[11:7]}));
      IMM_B:   imm = XLEN'($signed({instruction[31], instruction[7],
                                    instruction[30:25], instruction[11:8], 1'b0}));
      IMM_J:   imm = XLEN'($signed({instruction[31], instruction[19:12],
                                    instruction[20], instruction[30:21], 1'b0}));
      IMM_U:   imm = XLEN'($signed({instruction[31:12], 12'b0}));
      IMM_Z:   imm = XLEN'(instruction[19:15]);
      IMM_SH:  imm = XLEN'(shamt);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate-generation stage at the decode/execute boundary. Decodes the
// immediate combinationally and holds it in a main output entry backed by a
// skid entry, so a stalled consumer never loses a decoded immediate.
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .instruction (instruction),
    .immsrc      (immsrc),
    .imm         (dec_imm),
    .illegal     (dec_illegal)
  );

  // Main (output-facing) entry.
  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_ill_q,   main_ill_d;

  // Skid entry: catches the one instruction accepted while main stalls.
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_ill_q,   skid_ill_d;

  logic accept;
  logic out_hs;

  // in_ready comes straight from a flop, so out_ready never reaches it
  // combinationally.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign out_hs   = main_valid_q && out_ready;

  // Next-state for both entries; flush wins, then FIFO-ordered refill.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_hs) begin
      if (skid_valid_q) begin
        // Older skid entry moves forward; a new accept backfills skid.
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_tag_d   = skid_tag_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_imm_d = dec_imm;
          skid_tag_d = in_tag;
          skid_ill_d = dec_illegal;
        end
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_tag_d   = in_tag;
        main_ill_d   = dec_illegal;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new instruction in skid.
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_tag_d   = in_tag;
      skid_ill_d   = dec_illegal;
    end
  end

  // Entry registers; reset empties both entries and zeroes the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_tag     = main_tag_q;
  assign out_illegal = main_ill_q;

endmodule
